// File: rtl/ct_had_etm_pkg.sv
// Shared encodings for the HAD ETM cross-trigger stage.
package ct_had_etm_pkg;

    // Width of the outgoing pulse-length counter.
    localparam int unsigned CntW = 4;

    // Outgoing-request FSM state encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StEnter = 2'd1,
        StExit  = 2'd2,
        StGap   = 2'd3
    } etm_out_st_e;

endpackage

// File: rtl/ct_had_etm_out_fsm.sv
// Outgoing enter/exit debug-request pulse generator. Queues core debug-mode
// edges and replays them as fixed-length, mutually exclusive levels with a
// one-cycle gap between pulses.
module ct_had_etm_out_fsm
    import ct_had_etm_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mode_rise_i,
    input  logic mode_fall_i,
    output logic x_enter_dbg_req_o,
    output logic x_exit_dbg_req_o
);

    localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC);

    etm_out_st_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            enter_pend_q, enter_pend_d;
    logic            exit_pend_q, exit_pend_d;
    // Direction of the pulse most recently issued (1 = exit); picks the GAP successor.
    logic            last_exit_q, last_exit_d;
    logic            start_enter, start_exit;

    // Next-state: queue edges in every state, launch pulses from IDLE/GAP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_exit_d  = last_exit_q;
        // A strobe arriving this cycle counts as pending, so IDLE can launch at once.
        enter_pend_d = enter_pend_q | mode_rise_i;
        exit_pend_d  = exit_pend_q | mode_fall_i;
        start_enter  = 1'b0;
        start_exit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enter_pend_d) begin
                    start_enter = 1'b1;
                end else if (exit_pend_d) begin
                    start_exit = 1'b1;
                end
            end
            StEnter, StExit: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= CntW'(1)) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                // Opposite direction first, then a repeat of the same one.
                if (last_exit_q) begin
                    if (enter_pend_d) begin
                        start_enter = 1'b1;
                    end else if (exit_pend_d) begin
                        start_exit = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (exit_pend_d) begin
                        start_exit = 1'b1;
                    end else if (enter_pend_d) begin
                        start_enter = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_enter) begin
            state_d      = StEnter;
            cnt_d        = PulseLd;
            enter_pend_d = 1'b0;
            last_exit_d  = 1'b0;
        end else if (start_exit) begin
            state_d      = StExit;
            cnt_d        = PulseLd;
            exit_pend_d  = 1'b0;
            last_exit_d  = 1'b1;
        end
    end

    // State, counter and pend-flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            enter_pend_q <= 1'b0;
            exit_pend_q  <= 1'b0;
            last_exit_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enter_pend_q <= enter_pend_d;
            exit_pend_q  <= exit_pend_d;
            last_exit_q  <= last_exit_d;
        end
    end

    assign x_enter_dbg_req_o = (state_q == StEnter);
    assign x_exit_dbg_req_o  = (state_q == StExit);

endmodule

// File: rtl/ct_had_etm_trig.sv
// HAD cross-trigger control: turns synchronized external enter/exit debug
// request levels into held halt/resume requests, and drives the outgoing
// enter/exit levels from core debug-mode transitions.
module ct_had_etm_trig
    import ct_had_etm_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 4
) (
    input  logic forever_cpuclk,
    input  logic cpurst,
    input  logic regs_etm_trig_en,
    input  logic x_enter_dbg_req_i,
    input  logic x_exit_dbg_req_i,
    input  logic had_core_dbg_mode,
    input  logic ctrl_etm_halt_ack,
    input  logic ctrl_etm_resume_ack,
    output logic etm_ctrl_halt_req,
    output logic etm_ctrl_resume_req,
    output logic x_enter_dbg_req_o,
    output logic x_exit_dbg_req_o
);

    logic enter_prev_q, exit_prev_q, mode_prev_q;
    logic halt_pend_q, halt_pend_d;
    logic resume_pend_q, resume_pend_d;
    logic enter_edge, exit_edge, mode_rise, mode_fall;

    assign enter_edge = x_enter_dbg_req_i & ~enter_prev_q;
    assign exit_edge  = x_exit_dbg_req_i & ~exit_prev_q;
    assign mode_rise  = had_core_dbg_mode & ~mode_prev_q;
    assign mode_fall  = ~had_core_dbg_mode & mode_prev_q;

    // Halt/resume pend flags; clear wins over set. The mode qualifier on each
    // set term drops whichever simultaneous edge is invalid for the current mode.
    always_comb begin
        halt_pend_d   = halt_pend_q;
        resume_pend_d = resume_pend_q;
        if (ctrl_etm_halt_ack || mode_rise || !regs_etm_trig_en) begin
            halt_pend_d = 1'b0;
        end else if (enter_edge && !had_core_dbg_mode) begin
            halt_pend_d = 1'b1;
        end
        if (ctrl_etm_resume_ack || mode_fall || !regs_etm_trig_en) begin
            resume_pend_d = 1'b0;
        end else if (exit_edge && had_core_dbg_mode) begin
            resume_pend_d = 1'b1;
        end
    end

    // Edge-detect history and request flops.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            enter_prev_q  <= 1'b0;
            exit_prev_q   <= 1'b0;
            mode_prev_q   <= 1'b0;
            halt_pend_q   <= 1'b0;
            resume_pend_q <= 1'b0;
        end else begin
            enter_prev_q  <= x_enter_dbg_req_i;
            exit_prev_q   <= x_exit_dbg_req_i;
            mode_prev_q   <= had_core_dbg_mode;
            halt_pend_q   <= halt_pend_d;
            resume_pend_q <= resume_pend_d;
        end
    end

    assign etm_ctrl_halt_req   = halt_pend_q;
    assign etm_ctrl_resume_req = resume_pend_q;

    ct_had_etm_out_fsm #(
        .PULSE_CYC (PULSE_CYC)
    ) u_out_fsm (
        .clk_i             (forever_cpuclk),
        .rst_i             (cpurst),
        .mode_rise_i       (mode_rise),
        .mode_fall_i       (mode_fall),
        .x_enter_dbg_req_o (x_enter_dbg_req_o),
        .x_exit_dbg_req_o  (x_exit_dbg_req_o)
    );

endmodule

// File: tb/tb_ct_had_etm_trig.sv
// Directed, table-driven bench for ct_had_etm_trig with PULSE_CYC = 4.
// Each vector's inputs are applied before a rising edge; the expected outputs
// are those visible just after that edge.
module tb_ct_had_etm_trig;

    // Input bits: {rst, en, xen, xex, mode, hack, rack}
    // Expected:   {halt_req, resume_req, x_enter_o, x_exit_o}
    typedef struct packed {
        logic [6:0] in;
        logic [3:0] exp;
    } vec_t;

    logic forever_cpuclk = 1'b0;
    logic cpurst = 1'b1;
    logic regs_etm_trig_en = 1'b0;
    logic x_enter_dbg_req_i = 1'b0;
    logic x_exit_dbg_req_i = 1'b0;
    logic had_core_dbg_mode = 1'b0;
    logic ctrl_etm_halt_ack = 1'b0;
    logic ctrl_etm_resume_ack = 1'b0;
    logic etm_ctrl_halt_req;
    logic etm_ctrl_resume_req;
    logic x_enter_dbg_req_o;
    logic x_exit_dbg_req_o;

    int checks = 0;
    int passed = 0;

    vec_t tbl[$];
    vec_t merge_seq[$];
    vec_t rst_seq[$];

    ct_had_etm_trig #(
        .PULSE_CYC (4)
    ) dut (
        .forever_cpuclk      (forever_cpuclk),
        .cpurst              (cpurst),
        .regs_etm_trig_en    (regs_etm_trig_en),
        .x_enter_dbg_req_i   (x_enter_dbg_req_i),
        .x_exit_dbg_req_i    (x_exit_dbg_req_i),
        .had_core_dbg_mode   (had_core_dbg_mode),
        .ctrl_etm_halt_ack   (ctrl_etm_halt_ack),
        .ctrl_etm_resume_ack (ctrl_etm_resume_ack),
        .etm_ctrl_halt_req   (etm_ctrl_halt_req),
        .etm_ctrl_resume_req (etm_ctrl_resume_req),
        .x_enter_dbg_req_o   (x_enter_dbg_req_o),
        .x_exit_dbg_req_o    (x_exit_dbg_req_o)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic step(input string name, input int idx, input vec_t v);
        logic [3:0] got;
        @(negedge forever_cpuclk);
        {cpurst, regs_etm_trig_en, x_enter_dbg_req_i, x_exit_dbg_req_i,
         had_core_dbg_mode, ctrl_etm_halt_ack, ctrl_etm_resume_ack} = v.in;
        @(posedge forever_cpuclk);
        #1;
        got = {etm_ctrl_halt_req, etm_ctrl_resume_req, x_enter_dbg_req_o, x_exit_dbg_req_o};
        checks++;
        if (got === v.exp) begin
            passed++;
        end else begin
            $display("FAIL %s step %0d: {halt,resume,xen_o,xex_o} got %b expected %b",
                     name, idx, got, v.exp);
        end
    endtask

    initial begin
        // Reset, halt/ack, disabled and wrong-mode edges, resume paths,
        // queued opposite pulse after a mode rise during EXIT, simultaneous edges.
        tbl.push_back({7'b1000000, 4'b0000});  // reset
        tbl.push_back({7'b1000000, 4'b0000});
        tbl.push_back({7'b0100000, 4'b0000});
        tbl.push_back({7'b0110000, 4'b1000});  // enter edge -> halt
        tbl.push_back({7'b0110000, 4'b1000});
        tbl.push_back({7'b0110000, 4'b1000});
        tbl.push_back({7'b0110010, 4'b0000});  // ack clears
        tbl.push_back({7'b0100000, 4'b0000});
        tbl.push_back({7'b0010000, 4'b0000});  // edge while disabled
        tbl.push_back({7'b0000000, 4'b0000});
        tbl.push_back({7'b0100100, 4'b0010});  // mode rise -> ENTER pulse
        tbl.push_back({7'b0110100, 4'b0010});  // enter edge in debug mode ignored
        tbl.push_back({7'b0101100, 4'b0110});  // exit edge -> resume
        tbl.push_back({7'b0101100, 4'b0110});
        tbl.push_back({7'b0101101, 4'b0000});  // resume ack; GAP
        tbl.push_back({7'b0100100, 4'b0000});  // IDLE
        tbl.push_back({7'b0101100, 4'b0100});  // resume again
        tbl.push_back({7'b0101000, 4'b0001});  // mode fall clears resume, EXIT pulse
        tbl.push_back({7'b0100000, 4'b0001});
        tbl.push_back({7'b0110000, 4'b1001});  // halt during EXIT
        tbl.push_back({7'b0110000, 4'b1001});
        tbl.push_back({7'b0110100, 4'b0000});  // mode rise clears halt; GAP, enter queued
        tbl.push_back({7'b0100100, 4'b0010});  // queued ENTER
        tbl.push_back({7'b0100100, 4'b0010});
        tbl.push_back({7'b0100100, 4'b0010});
        tbl.push_back({7'b0100100, 4'b0010});
        tbl.push_back({7'b0100100, 4'b0000});  // GAP
        tbl.push_back({7'b0100100, 4'b0000});  // IDLE
        tbl.push_back({7'b0100000, 4'b0001});  // mode fall -> EXIT
        tbl.push_back({7'b0111000, 4'b1001});  // simultaneous edges, mode 0 -> halt only
        tbl.push_back({7'b0111000, 4'b1001});
        tbl.push_back({7'b0100010, 4'b0001});
        tbl.push_back({7'b0100000, 4'b0000});
        tbl.push_back({7'b0100000, 4'b0000});

        // Repeated edges while busy merge into single queued pulses.
        merge_seq.push_back({7'b0100100, 4'b0010});  // ENTER starts
        merge_seq.push_back({7'b0100000, 4'b0010});  // exit queued
        merge_seq.push_back({7'b0100100, 4'b0010});  // enter queued
        merge_seq.push_back({7'b0100000, 4'b0010});  // exit merges
        merge_seq.push_back({7'b0100000, 4'b0000});  // GAP
        merge_seq.push_back({7'b0100000, 4'b0001});  // opposite (EXIT) first
        merge_seq.push_back({7'b0100000, 4'b0001});
        merge_seq.push_back({7'b0100000, 4'b0001});
        merge_seq.push_back({7'b0100000, 4'b0001});
        merge_seq.push_back({7'b0100000, 4'b0000});  // GAP
        merge_seq.push_back({7'b0100000, 4'b0010});  // queued ENTER
        merge_seq.push_back({7'b0100000, 4'b0010});
        merge_seq.push_back({7'b0100000, 4'b0010});
        merge_seq.push_back({7'b0100000, 4'b0010});
        merge_seq.push_back({7'b0100000, 4'b0000});  // GAP
        merge_seq.push_back({7'b0100000, 4'b0000});  // IDLE, merged exit already consumed
        merge_seq.push_back({7'b0100000, 4'b0000});

        // Reset mid-pulse with an exit queued and a halt pending.
        rst_seq.push_back({7'b0100100, 4'b0010});
        rst_seq.push_back({7'b0100000, 4'b0010});  // exit queued
        rst_seq.push_back({7'b0110000, 4'b1010});  // halt pending
        rst_seq.push_back({7'b1100000, 4'b0000});  // reset drops everything
        for (int i = 0; i < 10; i++) begin
            rst_seq.push_back({7'b0100000, 4'b0000});
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step("table", i, tbl[i]);
        end
        for (int i = 0; i < merge_seq.size(); i++) begin
            step("merge", i, merge_seq[i]);
        end
        for (int i = 0; i < rst_seq.size(); i++) begin
            step("reset_mid_pulse", i, rst_seq[i]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Outgoing levels must never overlap.
    always @(negedge forever_cpuclk) begin
        if (x_enter_dbg_req_o && x_exit_dbg_req_o) begin
            checks++;
            $display("FAIL overlap: xen_o=%b xex_o=%b expected not both 1",
                     x_enter_dbg_req_o, x_exit_dbg_req_o);
        end
    end

endmodule
